vendo_np: RTL and testbench

Parametrised N-peso vending controller; the successor to the fixed 2-peso machine. It accepts 1-, 5- and 10-peso coin pulses and accumulates credit against a parameter `PRICE`. It issues a one-cycle `disp` pulse, then pays out the remainder as one `change` cycle per peso. It adds cancel/refund, overflow rejection and a visible credit count, and sits between the coin-acceptor pulse synchronisers and the dispenser/hopper drivers.

---
 rtl/vendo_np.sv | 120 ++++++++++++
 tb/tb_vendo_np.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vendo_np.sv
// Parametrised N-peso vending controller: coin credit accumulation, single-cycle
// dispense, per-peso change payout, cancel/refund and overflow rejection.
module vendo_np #(
    parameter int unsigned PRICE      = 2,
    parameter int unsigned MAX_CREDIT = 20,
    parameter int unsigned CW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p1,
    input  logic          p5,
    input  logic          p10,
    input  logic          cancel,
    output logic          disp,
    output logic          change,
    output logic          reject,
    output logic          busy,
    output logic [CW-1:0] credit,
    output logic [1:0]    cstate
);

    localparam int unsigned SW = CW + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COLLECT = 2'b01,
        S_VEND    = 2'b10,
        S_CHANGE  = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_next_credit;
    logic          r_disp;
    logic          r_change;
    logic          r_busy;
    logic          r_reject;
    logic          w_reject;
    logic          w_coin;
    logic [SW-1:0] w_coin_val;
    logic [SW-1:0] w_base;
    logic [SW-1:0] w_sum;

    // Total coin value this cycle; IDLE treats any stale credit as zero.
    assign w_coin_val = (p1  ? SW'(1)  : SW'(0))
                      + (p5  ? SW'(5)  : SW'(0))
                      + (p10 ? SW'(10) : SW'(0));
    assign w_coin     = p1 | p5 | p10;
    assign w_base     = (r_state == S_IDLE) ? SW'(0) : SW'(r_credit);
    assign w_sum      = w_base + w_coin_val;

    always_comb begin
        w_next_state  = r_state;
        w_next_credit = r_credit;
        w_reject      = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                w_next_credit = CW'(w_base);
                if ((r_state == S_COLLECT) && cancel) begin
                    w_next_state = S_CHANGE;
                    w_reject     = w_coin;
                end else if (w_coin) begin
                    if (w_sum <= SW'(MAX_CREDIT)) begin
                        w_next_credit = CW'(w_sum);
                        w_next_state  = (w_sum >= SW'(PRICE)) ? S_VEND : S_COLLECT;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_reject = w_coin;
                if (r_credit > CW'(PRICE)) begin
                    w_next_credit = r_credit - CW'(PRICE);
                    w_next_state  = S_CHANGE;
                end else begin
                    w_next_credit = CW'(0);
                    w_next_state  = S_IDLE;
                end
            end
            S_CHANGE: begin
                w_reject = w_coin;
                if (r_credit > CW'(1)) begin
                    w_next_credit = r_credit - CW'(1);
                end else begin
                    w_next_credit = CW'(0);
                    w_next_state  = S_IDLE;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with cstate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_credit <= CW'(0);
            r_disp   <= 1'b0;
            r_change <= 1'b0;
            r_busy   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_credit <= w_next_credit;
            r_disp   <= (w_next_state == S_VEND);
            r_change <= (w_next_state == S_CHANGE);
            r_busy   <= (w_next_state == S_VEND) || (w_next_state == S_CHANGE);
            r_reject <= w_reject;
        end
    end

    assign disp   = r_disp;
    assign change = r_change;
    assign busy   = r_busy;
    assign reject = r_reject;
    assign credit = r_credit;
    assign cstate = r_state;

endmodule

// File: tb/tb_vendo_np.sv
// Bench for vendo_np: two parameterisations share one stimulus stream and are
// checked every cycle against a behavioural credit/phase model.
module tb_vendo_np;

    logic clk = 1'b0;
    logic reset;
    logic p1, p5, p10, cancel;

    logic       disp0, change0, reject0, busy0;
    logic [4:0] credit0;
    logic [1:0] cstate0;
    logic       disp1, change1, reject1, busy1;
    logic [4:0] credit1;
    logic [1:0] cstate1;

    always #5 clk = ~clk;

    vendo_np #(.PRICE(2), .MAX_CREDIT(20), .CW(5)) u_dut0 (
        .clk(clk), .reset(reset), .p1(p1), .p5(p5), .p10(p10), .cancel(cancel),
        .disp(disp0), .change(change0), .reject(reject0), .busy(busy0),
        .credit(credit0), .cstate(cstate0)
    );

    vendo_np #(.PRICE(12), .MAX_CREDIT(15), .CW(5)) u_dut1 (
        .clk(clk), .reset(reset), .p1(p1), .p5(p5), .p10(p10), .cancel(cancel),
        .disp(disp1), .change(change1), .reject(reject1), .busy(busy1),
        .credit(credit1), .cstate(cstate1)
    );

    // Reference model: phase 0 idle, 1 collecting, 2 vending, 3 paying change.
    int price [2] = '{2, 12};
    int maxc  [2] = '{20, 15};
    int m_ph  [2];
    int m_cr  [2];
    bit m_rej [2];

    int n_vec = 0;
    int n_err = 0;
    int busy0_cnt = 0;
    int disp0_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]  = 0;
            m_cr[i]  = 0;
            m_rej[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int v;
        v = (p1 ? 1 : 0) + (p5 ? 5 : 0) + (p10 ? 10 : 0);
        for (int i = 0; i < 2; i++) begin
            m_rej[i] = 1'b0;
            if (m_ph[i] <= 1) begin
                if (m_ph[i] == 1 && cancel) begin
                    m_ph[i]  = 3;
                    m_rej[i] = (v > 0);
                end else if (v > 0) begin
                    if (m_cr[i] + v <= maxc[i]) begin
                        m_cr[i] += v;
                        m_ph[i] = (m_cr[i] >= price[i]) ? 2 : 1;
                    end else begin
                        m_rej[i] = 1'b1;
                    end
                end
            end else if (m_ph[i] == 2) begin
                m_rej[i] = (v > 0);
                m_cr[i] -= price[i];
                m_ph[i] = (m_cr[i] == 0) ? 0 : 3;
            end else begin
                m_rej[i] = (v > 0);
                m_cr[i] -= 1;
                if (m_cr[i] == 0) m_ph[i] = 0;
            end
        end
    endtask

    function automatic logic [10:0] expv(input int i);
        return {2'(m_ph[i]), 5'(m_cr[i]), m_ph[i] == 2, m_ph[i] == 3, m_ph[i] >= 2, m_rej[i]};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_d0"}, 32'({cstate0, credit0, disp0, change0, busy0, reject0}), 32'(expv(0)));
        chk({tag, "_d1"}, 32'({cstate1, credit1, disp1, change1, busy1, reject1}), 32'(expv(1)));
        if (busy0) busy0_cnt++;
        if (disp0) disp0_cnt++;
    endtask

    task automatic cycle(input bit a, input bit b, input bit c, input bit d);
        @(negedge clk);
        check_all("cyc");
        p1 = a; p5 = b; p10 = c; cancel = d;
        @(posedge clk);
        model_step();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Pulls reset low between clock edges; outputs must clear before the next edge.
    task automatic async_rst();
        #3 reset = 1'b0;
        p1 = 1'b0; p5 = 1'b0; p10 = 1'b0; cancel = 1'b0;
        #1 model_reset();
        check_all("arst");
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        p1 = 1'b0; p5 = 1'b0; p10 = 1'b0; cancel = 1'b0;
        model_reset();
        #12 check_all("por");
        @(negedge clk) reset = 1'b1;

        // exact-price sale with two single coins
        disp0_cnt = 0;
        cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(1, 0, 0, 0);
        drain(4);
        chk("disp_once", 32'(disp0_cnt), 32'd1);

        // p5 sale with three pesos of change
        busy0_cnt = 0;
        cycle(0, 1, 0, 0);
        drain(8);
        chk("busy_len", 32'(busy0_cnt), 32'd4);

        // refund of a partial credit on the PRICE=12 unit
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 1);
        drain(22);

        // overflow reject on the MAX_CREDIT=15 unit, then exact completion
        cycle(0, 0, 1, 0); cycle(0, 0, 1, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        drain(22);

        // combined coins plus a coin injected during payout
        cycle(1, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);
        drain(10);

        // async reset in the middle of change payout, then a normal sale
        cycle(0, 0, 1, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
        async_rst();
        cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        drain(22);

        // random coins, cancels and occasional resets
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) async_rst();
        end
        drain(24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
